// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stim_pkg
// Description : Shared encodings and helpers for the AND-gate stimulus
//               sequencer (FSM state codes, binary-to-Gray conversion).
// Revision    : 1.0 - initial release
// ============================================================================
package stim_pkg;

    localparam int c_vec_w = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic logic [c_vec_w-1:0] bin2gray(input logic [c_vec_w-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage : stim_pkg
`default_nettype wire

// File: rtl/stim_hold_counter.sv
`default_nettype none
// ============================================================================
// Module      : stim_hold_counter
// Description : Hold-phase cycle counter: load to 1, count up on enable,
//               flag when the count equals the supplied limit.
// Revision    : 1.0 - initial release
// ============================================================================
module stim_hold_counter #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [HOLD_W-1:0] i_limit,
    output logic              o_tc
);

    logic [HOLD_W-1:0] r_count_q;
    logic [HOLD_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = HOLD_W'(1);
        end else if (i_en) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_tc = (r_count_q == i_limit);

endmodule : stim_hold_counter
`default_nettype wire

// File: rtl/and_gate_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : and_gate_stim_gen
// Description : Sweeps every 3-bit input vector into a three-input AND gate
//               over a valid/ready handshake with a programmable hold time.
//               Define STIM_GRAY_EN to drive vectors in Gray order.
// Revision    : 1.0 - initial release
// ============================================================================
module and_gate_stim_gen
    import stim_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int HOLD_W = 4,
    parameter int SWP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [SWP_W-1:0]  num_sweeps,
    input  logic              vec_ready,
    output logic              out_a,
    output logic              out_b,
    output logic              out_c,
    output logic              vec_valid,
    output logic [WIDTH-1:0]  vec_idx,
    output logic              busy,
    output logic              done
);

    logic [1:0]        r_state_q;
    logic [1:0]        w_state_d;
    logic [WIDTH-1:0]  r_idx_q;
    logic [WIDTH-1:0]  w_idx_d;
    logic [SWP_W-1:0]  r_sweep_q;
    logic [SWP_W-1:0]  w_sweep_d;
    logic [HOLD_W-1:0] r_hold_q;
    logic [HOLD_W-1:0] w_hold_d;
    logic [SWP_W-1:0]  r_nsw_q;
    logic [SWP_W-1:0]  w_nsw_d;

    logic              w_cnt_load;
    logic              w_cnt_en;
    logic              w_hold_tc;
    logic              w_last_idx;
    logic              w_last_sweep;
    logic              w_driving;
    logic [WIDTH-1:0]  w_vec;

    assign w_last_idx   = (r_idx_q == {WIDTH{1'b1}});
    assign w_last_sweep = (r_sweep_q == (r_nsw_q - 1'b1));

    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_sweep_d  = r_sweep_q;
        w_hold_d   = r_hold_q;
        w_nsw_d    = r_nsw_q;
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (start) begin
                    // Zero settings are promoted to one so a run always makes progress.
                    w_hold_d  = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                    w_nsw_d   = (num_sweeps == '0) ? SWP_W'(1) : num_sweeps;
                    w_idx_d   = '0;
                    w_sweep_d = '0;
                    w_state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (vec_ready) begin
                    w_cnt_load = 1'b1;
                    w_state_d  = HOLD;
                end
            end
            HOLD: begin
                if (w_hold_tc) begin
                    if (!w_last_idx) begin
                        w_idx_d   = r_idx_q + 1'b1;
                        w_state_d = DRIVE;
                    end else if (!w_last_sweep) begin
                        w_idx_d   = '0;
                        w_sweep_d = r_sweep_q + 1'b1;
                        w_state_d = DRIVE;
                    end else begin
                        w_idx_d   = '0;
                        w_state_d = DONE;
                    end
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_idx_q   <= '0;
            r_sweep_q <= '0;
            r_hold_q  <= '0;
            r_nsw_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_sweep_q <= w_sweep_d;
            r_hold_q  <= w_hold_d;
            r_nsw_q   <= w_nsw_d;
        end
    end

    stim_hold_counter #(
        .HOLD_W (HOLD_W)
    ) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cnt_load),
        .i_en    (w_cnt_en),
        .i_limit (r_hold_q),
        .o_tc    (w_hold_tc)
    );

`ifdef STIM_GRAY_EN
    assign w_vec = bin2gray(r_idx_q);
`else
    assign w_vec = r_idx_q;
`endif

    // The vector stays on the pins through HOLD so the gate output can settle.
    assign w_driving = (r_state_q == DRIVE) || (r_state_q == HOLD);

    assign out_a     = w_driving & w_vec[2];
    assign out_b     = w_driving & w_vec[1];
    assign out_c     = w_driving & w_vec[0];
    assign vec_valid = (r_state_q == DRIVE);
    assign vec_idx   = r_idx_q;
    assign busy      = (r_state_q != IDLE);
    assign done      = (r_state_q == DONE);

endmodule : and_gate_stim_gen
`default_nettype wire

// File: tb/tb_and_gate_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_and_gate_stim_gen
// Description : Self-checking bench for and_gate_stim_gen against a
//               sweep-walking reference model with randomized handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and_gate_stim_gen;

    localparam int WIDTH  = 3;
    localparam int HOLD_W = 4;
    localparam int SWP_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [HOLD_W-1:0] hold_cycles;
    logic [SWP_W-1:0]  num_sweeps;
    logic              vec_ready;
    logic              out_a;
    logic              out_b;
    logic              out_c;
    logic              vec_valid;
    logic [WIDTH-1:0]  vec_idx;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    and_gate_stim_gen #(
        .WIDTH  (WIDTH),
        .HOLD_W (HOLD_W),
        .SWP_W  (SWP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold_cycles (hold_cycles),
        .num_sweeps  (num_sweeps),
        .vec_ready   (vec_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_c       (out_c),
        .vec_valid   (vec_valid),
        .vec_idx     (vec_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Expected a/b/c pattern for sweep position i.
    function automatic logic [2:0] model_vec(input int i);
`ifdef STIM_GRAY_EN
        return 3'(i ^ (i >> 1));
`else
        return 3'(i);
`endif
    endfunction

    // Observation word: {busy, done, valid, a, b, c, idx}
    function automatic logic [8:0] snap();
        return {busy, done, vec_valid, out_a, out_b, out_c, vec_idx};
    endfunction

    task automatic do_start(input int h, input int n);
        @(negedge clk);
        hold_cycles = HOLD_W'(h);
        num_sweeps  = SWP_W'(n);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Walks the expected sweep from the first DRIVE cycle to two IDLE cycles.
    task automatic check_run(input int h, input int n, input int rdy_pct,
                             input int stall_idx, input int stall_len, input bit poke,
                             input string tag, output int cyc, output int acc);
        logic [8:0] e;
        int stall;
        int guard;
        cyc = 0;
        acc = 0;
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 8; i++) begin
                stall = 0;
                guard = 0;
                forever begin
                    e = {1'b1, 1'b0, 1'b1, model_vec(i), 3'(i)};
                    checks++;
                    if (snap() !== e) begin
                        errors++;
                        $display("FAIL %s drive s%0d i%0d: got %b want %b", tag, s, i, snap(), e);
                    end
                    if (i == stall_idx && stall < stall_len) begin
                        vec_ready = 1'b0;
                        stall++;
                    end else if (guard >= 20) begin
                        vec_ready = 1'b1;
                    end else begin
                        vec_ready = ($urandom_range(99) < rdy_pct);
                    end
                    guard++;
                    if (poke) begin
                        start       = 1'($urandom_range(1));
                        hold_cycles = HOLD_W'($urandom);
                        num_sweeps  = SWP_W'($urandom);
                    end
                    cyc++;
                    @(negedge clk);
                    if (vec_ready) break;
                end
                acc++;
                for (int k = 0; k < h; k++) begin
                    e = {1'b1, 1'b0, 1'b0, model_vec(i), 3'(i)};
                    checks++;
                    if (snap() !== e) begin
                        errors++;
                        $display("FAIL %s hold s%0d i%0d k%0d: got %b want %b", tag, s, i, k, snap(), e);
                    end
                    vec_ready = 1'($urandom_range(1));
                    if (poke) start = 1'($urandom_range(1));
                    cyc++;
                    @(negedge clk);
                end
            end
        end
        e = {1'b1, 1'b1, 1'b0, 3'b000, 3'b000};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL %s done: got %b want %b", tag, snap(), e);
        end
        start = poke;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (snap() !== 9'b0) begin
                errors++;
                $display("FAIL %s idle%0d: got %b want %b", tag, k, snap(), 9'b0);
            end
            if (k == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [8:0] e;
        int cyc;
        int acc;
        rst = 1'b1; start = 1'b0; vec_ready = 1'b0; hold_cycles = '0; num_sweeps = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (snap() !== 9'b0) begin
                errors++;
                $display("FAIL reset_init: got %b want %b", snap(), 9'b0);
            end
        end
        rst = 1'b0;
        do_start(5, 1);
        vec_ready = 1'b1;
        @(negedge clk);
        e = {1'b1, 1'b0, 1'b0, model_vec(0), 3'd0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL reset_prehold: got %b want %b", snap(), e);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (snap() !== 9'b0) begin
                errors++;
                $display("FAIL reset_midrun: got %b want %b", snap(), 9'b0);
            end
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (snap() !== 9'b0) begin
                errors++;
                $display("FAIL reset_release: got %b want %b", snap(), 9'b0);
            end
        end
        do_start(1, 1);
        check_run(1, 1, 100, -1, 0, 1'b0, "reset_restart", cyc, acc);
    endtask

    task automatic test_binary_sweep();
        int cyc;
        int acc;
        do_start(1, 1);
        check_run(1, 1, 100, -1, 0, 1'b0, "sweep", cyc, acc);
        checks++;
        if (cyc !== 16 || acc !== 8) begin
            errors++;
            $display("FAIL sweep_timing: got cyc=%0d acc=%0d want cyc=16 acc=8", cyc, acc);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int acc;
        do_start(2, 1);
        check_run(2, 1, 100, 3, 5, 1'b0, "backpressure", cyc, acc);
        checks++;
        if (cyc !== 29) begin
            errors++;
            $display("FAIL backpressure_timing: got cyc=%0d want 29", cyc);
        end
    endtask

    task automatic test_zero_config();
        int cyc;
        int acc;
        do_start(0, 0);
        check_run(1, 1, 100, -1, 0, 1'b0, "zero_cfg", cyc, acc);
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL zero_cfg_timing: got cyc=%0d want 16", cyc);
        end
        do_start(0, 2);
        check_run(1, 2, 100, -1, 0, 1'b0, "two_sweeps", cyc, acc);
        checks++;
        if (acc !== 16 || cyc !== 32) begin
            errors++;
            $display("FAIL two_sweeps_count: got acc=%0d cyc=%0d want acc=16 cyc=32", acc, cyc);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        int acc;
        do_start(3, 1);
        check_run(3, 1, 70, -1, 0, 1'b1, "start_ignored", cyc, acc);
        do_start(1, 1);
        check_run(1, 1, 100, -1, 0, 1'b0, "start_again", cyc, acc);
    endtask

    task automatic test_random();
        int h;
        int n;
        int cyc;
        int acc;
        for (int r = 0; r < 6; r++) begin
            h = $urandom_range(5, 0);
            n = $urandom_range(2, 0);
            do_start(h, n);
            check_run((h == 0) ? 1 : h, (n == 0) ? 1 : n, $urandom_range(100, 30),
                      $urandom_range(7, 0), $urandom_range(4, 0), 1'($urandom_range(1)),
                      "random", cyc, acc);
            checks++;
            if (acc !== 8 * ((n == 0) ? 1 : n)) begin
                errors++;
                $display("FAIL random_accepts: got %0d want %0d", acc, 8 * ((n == 0) ? 1 : n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_binary_sweep();
        test_backpressure();
        test_zero_config();
        test_ignored_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_and_gate_stim_gen
`default_nettype wire
